// File: rtl/gate_sweep_checker.sv
// Sweeps every input vector of a gate under test and compares its output against a truth table.
// Optional first-mismatch capture is enabled by defining GATE_SWEEP_FIRST_FAIL_EN.
module gate_sweep_checker #(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [(1<<N_IN)-1:0]   expected_tt,
  output logic [N_IN-1:0]        stim,
  input  logic                   y,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [N_IN:0]          err_count,
  output logic [(1<<N_IN)-1:0]   captured_tt
`ifdef GATE_SWEEP_FIRST_FAIL_EN
  ,
  output logic [N_IN-1:0]        first_fail,
  output logic                   first_fail_vld
`endif
);

  localparam int unsigned NumVec = 1 << N_IN;
  localparam logic [N_IN-1:0] LastVec = N_IN'(NumVec - 1);
  localparam logic [3:0] SettleCnt = 4'(SETTLE);

  typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

  state_e              state_q, state_d;
  logic [N_IN-1:0]     stim_q, stim_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [NumVec-1:0]   exp_q, exp_d;
  logic [NumVec-1:0]   cap_q, cap_d;
  logic [N_IN:0]       err_q, err_d;
  logic                pass_q, pass_d;
  logic                mismatch;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
  logic [N_IN-1:0]     ff_q, ff_d;
  logic                ffv_q, ffv_d;
`endif

  always_comb begin
    state_d  = state_q;
    stim_d   = stim_q;
    cnt_d    = cnt_q;
    exp_d    = exp_q;
    cap_d    = cap_q;
    err_d    = err_q;
    pass_d   = pass_q;
    mismatch = 1'b0;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
    ff_d     = ff_q;
    ffv_d    = ffv_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          exp_d   = expected_tt;
          cap_d   = '0;
          err_d   = '0;
          pass_d  = 1'b0;
          stim_d  = '0;
          cnt_d   = SettleCnt;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
          ff_d    = '0;
          ffv_d   = 1'b0;
`endif
        end
      end
      StRun: begin
        if (cnt_q == 4'd0) begin
          // Sample only in the last cycle of the hold window.
          mismatch      = (y != exp_q[stim_q]);
          cap_d[stim_q] = y;
          if (mismatch) begin
            err_d = err_q + (N_IN+1)'(1);
          end
`ifdef GATE_SWEEP_FIRST_FAIL_EN
          if (mismatch && !ffv_q) begin
            ff_d  = stim_q;
            ffv_d = 1'b1;
          end
`endif
          if (stim_q != LastVec) begin
            stim_d = stim_q + N_IN'(1);
            cnt_d  = SettleCnt;
          end else begin
            // Verdict uses the updated count so a final-vector mismatch is included.
            state_d = StFinish;
            stim_d  = '0;
            pass_d  = (err_d == '0);
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      stim_q  <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      cap_q   <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
      ff_q    <= '0;
      ffv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      cap_q   <= cap_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
      ff_q    <= ff_d;
      ffv_q   <= ffv_d;
`endif
    end
  end

  assign stim        = stim_q;
  assign busy        = (state_q != StIdle);
  // A reset landing in the finish cycle suppresses the done pulse.
  assign done        = (state_q == StFinish) && !rst;
  assign pass        = pass_q;
  assign err_count   = err_q;
  assign captured_tt = cap_q;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
  assign first_fail     = ff_q;
  assign first_fail_vld = ffv_q;
`endif

endmodule

// File: doc/gate_sweep_checker.md
GATE_SWEEP_CHECKER -- requirements
Module: gate_sweep_checker

Interface
REQ-001 Parameter N_IN, default 2: number of gate inputs driven; legal range 1..6.
REQ-002 Parameter SETTLE, default 1: extra hold cycles per vector before y is sampled; legal range 0..15.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a full truth-table sweep; honoured only in IDLE.
REQ-006 expected_tt  input  2**N_IN  expected gate output; bit i = expected y when stim == i; latched on accepted start.
REQ-007 stim  output  N_IN  vector driven to gate under test; stim[N_IN-1] is the first-listed input (a), stim[0] the last (b).
REQ-008 y  input  1  gate-under-test output.
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  one-cycle pulse at sweep end.
REQ-011 pass  output  1  1 when the last completed sweep had zero mismatches.
REQ-012 err_count  output  N_IN+1  mismatch count of the current or last sweep.
REQ-013 captured_tt  output  2**N_IN  sampled y per vector; bit i = y sampled for stim == i.

Function
REQ-014 FSM states are IDLE, RUN and FINISH; the state after reset is IDLE.
REQ-015 IDLE with start=1 at an edge: latch expected_tt, clear err_count, captured_tt and pass, load stim=0 and hold counter=SETTLE, then enter RUN.
REQ-016 RUN: each vector is held for SETTLE+1 cycles; y is sampled in the last cycle of the window only.
REQ-017 On sample: captured_tt[stim] <= y; if y != latched expected_tt[stim], err_count increments by 1.
REQ-018 After sampling: if stim < 2**N_IN-1, stim increments and the counter reloads; otherwise go to FINISH.
REQ-019 FINISH, one cycle: done=1; pass=1 if err_count==0 (including a final-vector mismatch); stim returns to 0; next state is IDLE.
REQ-020 busy=1 in RUN and FINISH; busy=0 in IDLE.
REQ-021 Latency: start sampled at edge 0, RUN occupies cycles 1..2**N_IN*(SETTLE+1), done occurs in the next cycle.
REQ-022 start in RUN or FINISH is ignored and has no side effects.
REQ-023 A change of expected_tt during a sweep has no effect on the sweep.
REQ-024 err_count saturation is not required; its width holds the maximum value 2**N_IN.
REQ-025 pass, err_count and captured_tt hold their values from FINISH until the next accepted start.

Reset
REQ-026 While rst=1, at every edge: state=IDLE, and stim, busy, done, pass, err_count and captured_tt are all 0.
REQ-027 rst overrides start in the same cycle.
REQ-028 rst during RUN or FINISH aborts the sweep: no done pulse and no partial pass.

Configuration
REQ-029 Macro GATE_SWEEP_FIRST_FAIL_EN.
REQ-030 Defined: adds outputs first_fail (N_IN wide) and first_fail_vld (1 bit).
REQ-031 Defined: on the first mismatch of a sweep, first_fail <= stim and first_fail_vld <= 1; later mismatches do not change them.
REQ-032 Defined: first_fail and first_fail_vld are cleared on accepted start and on rst.
REQ-033 Not defined: these ports and their logic are absent; all other behaviour is identical.

Verification
REQ-034 Reset: rst=1 for 2 cycles, then idle -> stim=00, busy=0, done=0, pass=0, err_count=0, captured_tt=0000.
REQ-035 N_IN=2, SETTLE=1, OR gate looped back, expected_tt=4'b1110, start at cycle 0 -> stim 00,01,10,11 each for 2 cycles; done at cycle 9; pass=1; err_count=0; captured_tt=1110.
REQ-036 Same setup with y tied to 0 -> done at cycle 9; pass=0; err_count=3; captured_tt=0000; with the macro defined, first_fail=01 and first_fail_vld=1.
REQ-037 OR sweep with start re-pulsed at cycle 4 -> exactly one done, at cycle 9; results as in REQ-035.
REQ-038 rst pulsed at cycle 5 of an OR sweep -> next cycle stim=00 and busy=0; no done; a fresh start then completes as in REQ-035.
REQ-039 N_IN=3, SETTLE=0, 3-input AND looped back, expected_tt=8'b1000_0000 -> done at cycle 9; pass=1; captured_tt=1000_0000.
